// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4-channel mux scan controller.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;
endpackage

// File: rtl/mux_scan_timer.sv
// Dwell counter: counts while enabled, pulses tc on the last dwell cycle and wraps to zero.
module mux_scan_timer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    assign tc = en && (count == LAST);

    // Held at zero whenever disabled so every scan begins with a full dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4:1 mux channel by channel and captures y into a 4-bit sample word.
// Optional macro MUX_SCAN_CONT_EN: after the output handshake, rescan immediately without start.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              y,
    output logic              s0,
    output logic              s1,
    output logic [NUM_CH-1:0] sample,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output state_e            state_dbg
);
    // Handshake: sample is offered while valid=1 and must not change until a
    // rising edge sees valid && ready; ready while valid=0 has no effect.

    state_e           state, state_nx;
    logic [SEL_W-1:0] channel;
    logic             tc;

    mux_scan_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state == SCAN),
        .tc  (tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SCAN;
            SCAN: if (tc && (channel == SEL_W'(NUM_CH - 1))) state_nx = HOLD;
            HOLD: begin
                if (ready) begin
`ifdef MUX_SCAN_CONT_EN
                    state_nx = SCAN;
`else
                    state_nx = IDLE;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // channel wraps from the last index back to 0 on the final capture,
    // so the select lines rest at 0 outside SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            channel <= '0;
            sample  <= '0;
        end else begin
            state <= state_nx;
            if (state == SCAN && tc) begin
                sample[channel] <= y;
                channel         <= channel + 1'b1;
            end
        end
    end

    assign s0        = channel[0];
    assign s1        = channel[1];
    assign valid     = (state == HOLD);
    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: DWELL=4 and DWELL=2 instances driven by a shared mux input word.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_v;
    logic       start_a, ready_a, start_b, ready_b;
    logic       s0_a, s1_a, valid_a, busy_a, y_a;
    logic       s0_b, s1_b, valid_b, busy_b, y_b;
    logic [3:0] sample_a, sample_b;
    state_e     dbg_a, dbg_b;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    always #5 clk = ~clk;

    assign y_a = in_v[{s1_a, s0_a}];
    assign y_b = in_v[{s1_b, s0_b}];

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .y(y_a), .s0(s0_a), .s1(s1_a),
        .sample(sample_a), .valid(valid_a), .ready(ready_a), .busy(busy_a),
        .state_dbg(dbg_a)
    );

    mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .y(y_b), .s0(s0_b), .s1(s1_b),
        .sample(sample_b), .valid(valid_b), .ready(ready_b), .busy(busy_b),
        .state_dbg(dbg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase 0 idle, 1 scanning, 2 holding. k counts cycles since the scan began;
    // the channel is k / dwell and a capture lands whenever k reaches a multiple of dwell.
    int         dw      [2] = '{4, 2};
    int         m_phase [2];
    int         m_k     [2];
    logic [3:0] m_sample[2];
    logic [1:0] st_v, rd_v;

    assign st_v = {start_b, start_a};
    assign rd_v = {ready_b, ready_a};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i]  = 0;
                m_k[i]      = 0;
                m_sample[i] = 4'b0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    0: if (st_v[i]) begin m_phase[i] = 1; m_k[i] = 0; end
                    1: begin
                        int ch;
                        ch = m_k[i] / dw[i];
                        m_k[i]++;
                        if (m_k[i] % dw[i] == 0) m_sample[i][ch] = in_v[ch];
                        if (m_k[i] == 4 * dw[i]) m_phase[i] = 2;
                    end
                    default: if (rd_v[i]) begin
`ifdef MUX_SCAN_CONT_EN
                        m_phase[i] = 1;
                        m_k[i]     = 0;
`else
                        m_phase[i] = 0;
`endif
                    end
                endcase
            end
        end
    end

    function automatic logic [1:0] exp_sel(input int i);
        return (m_phase[i] == 1) ? 2'(m_k[i] / dw[i]) : 2'b00;
    endfunction

    function automatic state_e exp_state(input int i);
        return (m_phase[i] == 0) ? IDLE : (m_phase[i] == 1) ? SCAN : HOLD;
    endfunction

    // Compare process: every cycle, both instances, all outputs.
    always @(posedge clk) begin
        #1;
        check("a_sel",    {s1_a, s0_a}, exp_sel(0));
        check("a_sample", sample_a, m_sample[0]);
        check("a_valid",  valid_a, m_phase[0] == 2);
        check("a_busy",   busy_a, m_phase[0] != 0);
        check("a_state",  dbg_a, exp_state(0));
        check("b_sel",    {s1_b, s0_b}, exp_sel(1));
        check("b_sample", sample_b, m_sample[1]);
        check("b_valid",  valid_b, m_phase[1] == 2);
        check("b_busy",   busy_b, m_phase[1] != 0);
        check("b_state",  dbg_b, exp_state(1));
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int idx);
        @(negedge clk);
        if (idx == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        if (idx == 0) start_a = 1'b0; else start_b = 1'b0;
    endtask

    task automatic wait_valid(input int idx, input int budget, inout int cnt);
        bit got;
        got = 1'b0;
        while (!got && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
            got = (idx == 0) ? valid_a : valid_b;
        end
        if (!got) check("valid_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        in_v = 4'b1010;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel",    {s1_a, s0_a}, 2'b00);
        check("rst_sample", sample_a, 4'b0000);
        check("rst_valid",  valid_a, 1'b0);
        check("rst_busy",   busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full scan, with a start pulse landing inside the channel 2 dwell.
        pulse_start(0);
        repeat (9) @(posedge clk);
        #1;
        check("scan_ch2", {s1_a, s0_a}, 2'b10);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        cycles = 10;
        wait_valid(0, 40, cycles);
        check("latency_dwell4", cycles, 16);
        check("sample_1010", sample_a, 4'b1010);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid",  valid_a, 1'b1);
            check("hold_sample", sample_a, 4'b1010);
        end
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        check("hs_valid", valid_a, 1'b0);
`ifdef MUX_SCAN_CONT_EN
        check("hs_busy_cont", busy_a, 1'b1);
        in_v = 4'b0011;
        cycles = 0;
        wait_valid(0, 40, cycles);
        check("latency_cont", cycles, 16);
        check("sample_0011", sample_a, 4'b0011);
        ready_a = 1'b0;
        in_v = 4'b1010;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
`else
        check("hs_busy", busy_a, 1'b0);
        ready_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_keeps_sample", sample_a, 4'b1010);
`endif

        // Reset in the middle of the channel 1 dwell.
        pulse_start(0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sel",    {s1_a, s0_a}, 2'b00);
        check("arst_sample", sample_a, 4'b0000);
        check("arst_valid",  valid_a, 1'b0);
        check("arst_busy",   busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(0);
        cycles = 0;
        wait_valid(0, 40, cycles);
        check("latency_after_rst", cycles, 16);
        check("sample_after_rst", sample_a, 4'b1010);
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;

        // DWELL=2 instance, ready held high from before the scan.
        ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("b_ready_idle_valid", valid_b, 1'b0);
        check("b_ready_idle_busy",  busy_b, 1'b0);
        pulse_start(1);
        cycles = 0;
        wait_valid(1, 20, cycles);
        check("latency_dwell2", cycles, 8);
        check("b_sample_1010", sample_b, 4'b1010);
        @(posedge clk);
        #1;
        check("b_hs_valid", valid_b, 1'b0);
        ready_b = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
